regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/rf_pkg.sv | 29 ++
 rtl/regfile_write_arbiter_wb_fifo.sv | 73 +++++++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file write types: entry record {rd,data}, source ids, round-robin pick.
// Latency: none (types and a pure combinational helper only).
// Backpressure: not applicable.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rf_entry_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    // Only one non-empty source wins outright; on a tie the source not granted last wins.
    function automatic src_t rr_pick(input logic s0_ne, input logic s1_ne, input src_t last);
        if (s0_ne && s1_ne) begin
            return (last == SRC0) ? SRC1 : SRC0;
        end else if (s1_ne) begin
            return SRC1;
        end
        return SRC0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Per-source write buffer: DEPTH-entry FIFO of {rd,data} with synchronous flush.
// Latency: an entry pushed at edge N is visible at head_o after edge N.
// Backpressure: full is based on the count at cycle start; a push into a full buffer is dropped even if it pops.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  rf_entry_t              push_dat_i,
    input  logic                   pop_i,
    output rf_entry_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    rf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and count; flush wins over any push or pop in the same cycle.
    always_comb begin
        push_ok  = push_i && !full_o && !flush_i;
        pop_ok   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: per-source buffers, round-robin pop, registered write port.
// Latency: entry accepted at edge N is popped and driven on regwrite/writereg/write_data at edge N+1.
// Backpressure: sN_ready drops while buffer N is full; one pop per cycle shared between sources.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_rd,
    input  logic [XLEN-1:0]       s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_rd,
    input  logic [XLEN-1:0]       s1_data,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] writereg,
    output logic [XLEN-1:0]       write_data,
    output logic                  busy
);

    rf_entry_t               s0_head, s1_head, head;
    logic                    s0_full, s1_full, s0_empty, s1_empty;
    logic [$clog2(DEPTH):0]  s0_cnt, s1_cnt;
    logic                    pop_any, s0_pop, s1_pop;
    src_t                    grant;

    logic                    regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0]   writereg_q, writereg_d;
    logic [XLEN-1:0]         write_data_q, write_data_d;
    src_t                    last_grant_q, last_grant_d;

    wb_fifo #(.DEPTH(DEPTH)) u_buf0 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_i     (s0_valid),
        .push_dat_i ({s0_rd, s0_data}),
        .pop_i      (s0_pop),
        .head_o     (s0_head),
        .full_o     (s0_full),
        .empty_o    (s0_empty),
        .count_o    (s0_cnt)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_buf1 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_i     (s1_valid),
        .push_dat_i ({s1_rd, s1_data}),
        .pop_i      (s1_pop),
        .head_o     (s1_head),
        .full_o     (s1_full),
        .empty_o    (s1_empty),
        .count_o    (s1_cnt)
    );

    assign s0_ready   = !s0_full;
    assign s1_ready   = !s1_full;
    assign regwrite   = regwrite_q;
    assign writereg   = writereg_q;
    assign write_data = write_data_q;
    assign busy       = (s0_cnt != '0) || (s1_cnt != '0) || regwrite_q;

    // Pick a source, pop its head and form the next write-port values; x0 writes are dropped.
    always_comb begin
        grant        = rr_pick(!s0_empty, !s1_empty, last_grant_q);
        pop_any      = (!s0_empty || !s1_empty) && !flush;
        s0_pop       = pop_any && (grant == SRC0);
        s1_pop       = pop_any && (grant == SRC1);
        head         = (grant == SRC1) ? s1_head : s0_head;
        regwrite_d   = 1'b0;
        writereg_d   = writereg_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        if (pop_any) begin
            last_grant_d = grant;
            if (head.rd != '0) begin
                regwrite_d   = 1'b1;
                writereg_d   = head.rd;
                write_data_d = head.data;
            end
        end
    end

    // Registered write port and arbitration history; SRC1 at reset lets source 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            writereg_q   <= '0;
            write_data_q <= '0;
            last_grant_q <= SRC1;
        end else begin
            regwrite_q   <= regwrite_d;
            writereg_q   <= writereg_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH=2) with hand-computed expected write sequences.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised through simultaneous s0/s1 traffic filling one buffer.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_rd = '0, s1_rd = '0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] write_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_rd      (s0_rd),
        .s0_data    (s0_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_rd      (s1_rd),
        .s1_data    (s1_data),
        .regwrite   (regwrite),
        .writereg   (writereg),
        .write_data (write_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL rst_s0_ready: got %b want 1", s0_ready); end
        checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL rst_s1_ready: got %b want 1", s1_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b want 0", regwrite); end
        checks++; if (writereg !== 5'd0) begin errors++; $display("FAIL rst_writereg: got %0d want 0", writereg); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_write_data: got %h want 0", write_data); end
        rst = 1'b0;
        #1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b%b want 11", s0_ready, s1_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_write();
        s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'h1234;
        checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", s0_ready); end
        tick();
        s0_valid = 1'b0;
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", regwrite); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_buf: got %b want 1", busy); end
        tick();
        checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL single_regwrite: got %b want 1", regwrite); end
        checks++; if (writereg !== 5'd5) begin errors++; $display("FAIL single_writereg: got %0d want 5", writereg); end
        checks++; if (write_data !== 32'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", write_data); end
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", regwrite); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
        checks++; if (writereg !== 5'd5) begin errors++; $display("FAIL single_writereg_hold: got %0d want 5", writereg); end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        do_reset();
        s0_valid = 1'b1; s0_rd = 5'd1; s0_data = 32'hA0;
        s1_valid = 1'b1; s1_rd = 5'd2; s1_data = 32'hB0;
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rr_first_idle: got %b want 0", regwrite); end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_rd   = (i % 2 == 0) ? 5'd1 : 5'd2;
            exp_data = (i % 2 == 0) ? 32'hA0 : 32'hB0;
            checks++; if (regwrite !== 1'b1 || writereg !== exp_rd || write_data !== exp_data) begin
                errors++; $display("FAIL rr_grant_%0d: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", i, regwrite, writereg, write_data, exp_rd, exp_data);
            end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drained_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'h300;
        s1_valid = 1'b1; s1_rd = 5'd4; s1_data = 32'h100;
        tick();
        s1_data = 32'h101;
        checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1: got %b want 1", s1_ready); end
        tick();
        s1_data = 32'h102;
        checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2: got %b want 0", s1_ready); end
        checks++; if (regwrite !== 1'b1 || writereg !== 5'd3) begin errors++; $display("FAIL bp_w0: got we=%b rd=%0d want we=1 rd=3", regwrite, writereg); end
        tick();
        checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", s1_ready); end
        checks++; if (writereg !== 5'd4 || write_data !== 32'h100) begin errors++; $display("FAIL bp_w1: got rd=%0d data=%h want rd=4 data=100", writereg, write_data); end
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL bp_third_accept: got ready=%b want 0", s1_ready); end
        checks++; if (writereg !== 5'd3) begin errors++; $display("FAIL bp_w2: got rd=%0d want 3", writereg); end
        tick();
        checks++; if (regwrite !== 1'b1 || writereg !== 5'd4 || write_data !== 32'h101) begin errors++; $display("FAIL bp_w3: got we=%b rd=%0d data=%h want we=1 rd=4 data=101", regwrite, writereg, write_data); end
        tick();
        checks++; if (writereg !== 5'd3) begin errors++; $display("FAIL bp_w4: got rd=%0d want 3", writereg); end
        tick();
        checks++; if (regwrite !== 1'b1 || writereg !== 5'd4 || write_data !== 32'h102) begin errors++; $display("FAIL bp_w5: got we=%b rd=%0d data=%h want we=1 rd=4 data=102", regwrite, writereg, write_data); end
        tick();
        checks++; if (regwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got we=%b busy=%b want 0 0", regwrite, busy); end
    endtask

    task automatic test_x0_write();
        s0_valid = 1'b1; s0_rd = 5'd0; s0_data = 32'hFFFF_FFFF;
        tick();
        s0_valid = 1'b0;
        checks++; if (s0_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL x0_buffered: got ready=%b busy=%b want 1 1", s0_ready, busy); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_we_accept: got %b want 0", regwrite); end
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_we_pop: got %b want 0", regwrite); end
        checks++; if (busy !== 1'b0 || s0_ready !== 1'b1) begin errors++; $display("FAIL x0_consumed: got busy=%b ready=%b want 0 1", busy, s0_ready); end
        checks++; if (writereg !== 5'd4 || write_data !== 32'h102) begin errors++; $display("FAIL x0_hold: got rd=%0d data=%h want rd=4 data=102", writereg, write_data); end
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL x0_we_after: got %b want 0", regwrite); end
    endtask

    task automatic test_flush();
        do_reset();
        s0_valid = 1'b1; s0_rd = 5'd6; s0_data = 32'h600;
        s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'h700;
        repeat (4) tick();
        // Occupancy is now s0=1, s1=2 and source 0 was granted last.
        s0_rd = 5'd9; s0_data = 32'hDEAD; s1_valid = 1'b0; flush = 1'b1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_fill: got %b%b want 10", s0_ready, s1_ready); end
        tick();
        flush = 1'b0; s0_valid = 1'b0;
        checks++; if (regwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_empty: got we=%b busy=%b want 0 0", regwrite, busy); end
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b%b want 11", s0_ready, s1_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL flush_no_write_%0d: got we=%b rd=%0d want 0", i, regwrite, writereg); end
        end
        s0_valid = 1'b1; s0_rd = 5'd10; s0_data = 32'hA;
        s1_valid = 1'b1; s1_rd = 5'd11; s1_data = 32'hB;
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
        checks++; if (regwrite !== 1'b1 || writereg !== 5'd11) begin errors++; $display("FAIL flush_last_grant: got we=%b rd=%0d want 1 11", regwrite, writereg); end
        tick();
        checks++; if (regwrite !== 1'b1 || writereg !== 5'd10) begin errors++; $display("FAIL flush_second: got we=%b rd=%0d want 1 10", regwrite, writereg); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_final_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        s0_valid = 1'b1; s0_rd = 5'd12; s0_data = 32'hC;
        s1_valid = 1'b1; s1_rd = 5'd13; s1_data = 32'hD;
        repeat (3) tick();
        checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", regwrite); end
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        checks++; if (regwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_now: got we=%b busy=%b want 0 0", regwrite, busy); end
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b%b want 11", s0_ready, s1_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_during_%0d: got %b want 0", i, regwrite); end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (regwrite !== 1'b0 || busy !== 1'b0 || s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
                errors++; $display("FAIL mid_after_%0d: got we=%b busy=%b ready=%b%b want 0 0 11", i, regwrite, busy, s0_ready, s1_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_x0_write();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
